// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate-generator pipeline.
// Holds the format codes, the RV opcode constants that select a format,
// and the sign-extension helper used to build every immediate.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SH  = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Sign-extend the low nbits of val to 64 bits (nbits in 1..32).
  // Left-align the field, then arithmetic-shift it back down.
  function automatic logic [63:0] sext(input logic [31:0] val, input logic [5:0] nbits);
    logic signed [63:0] t;
    logic [6:0]         sh;
    sh = 7'd64 - {1'b0, nbits};
    t  = {32'd0, val} << sh;
    t  = t >>> sh;
    return t;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_skid.sv
// Two-entry skid buffer (main + skid register) with a registered ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid/o_ready/i_data   upstream handshake and payload
//   o_valid/i_ready/o_data   downstream handshake and payload (main entry)
// o_ready is 0 exactly while the skid entry holds data.
module skid_buffer #(
  parameter int W = 67
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_vld, r_skid_vld, r_ready;
  logic [W-1:0] r_main_data, r_skid_data;

  logic         w_accept, w_deliver;
  logic         w_main_vld_nxt, w_skid_vld_nxt;
  logic [W-1:0] w_main_data_nxt, w_skid_data_nxt;

  assign w_accept  = i_valid & r_ready;
  assign w_deliver = r_main_vld & i_ready;

  always_comb begin
    w_main_vld_nxt  = r_main_vld;
    w_main_data_nxt = r_main_data;
    w_skid_vld_nxt  = r_skid_vld;
    w_skid_data_nxt = r_skid_data;
    if (w_deliver) begin
      // A full skid implies r_ready=0, so no accept can coincide here.
      if (r_skid_vld) begin
        w_main_data_nxt = r_skid_data;
        w_skid_vld_nxt  = 1'b0;
      end else begin
        w_main_vld_nxt = w_accept;
        if (w_accept) w_main_data_nxt = i_data;
      end
    end else if (w_accept) begin
      if (r_main_vld) begin
        w_skid_vld_nxt  = 1'b1;
        w_skid_data_nxt = i_data;
      end else begin
        w_main_vld_nxt  = 1'b1;
        w_main_data_nxt = i_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_ready     <= 1'b1;
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      r_main_vld  <= w_main_vld_nxt;
      r_skid_vld  <= w_skid_vld_nxt;
      r_ready     <= ~w_skid_vld_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_main_vld;
  assign o_data  = r_main_data;

endmodule

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: combinational decode of format and immediate,
// followed by a 2-entry skid buffer; one-cycle latency, full throughput.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr       instruction input handshake
//   out_valid/out_ready              result handshake
//   out_imm[XLEN]/out_fmt[3]/out_instr[32]   decoded result + pass-through
//   illegal_cnt[CNT_W]               saturating count of accepted ILL opcodes
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = XLEN + 3 + 32;

  fmt_e            w_fmt;
  logic [XLEN-1:0] w_imm;
  logic [PW-1:0]   w_out_data;
  logic            w_accept;
  logic [CNT_W-1:0] r_ill_cnt;

  always_comb begin
    w_fmt = FMT_ILL;
    unique case (in_instr[6:0])
      OPC_OP_IMM: w_fmt = (in_instr[13:12] == 2'b01) ? FMT_SH : FMT_I; // funct3 001/101
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: w_fmt = FMT_I;
      OPC_STORE:          w_fmt = FMT_S;
      OPC_BRANCH:         w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
      OPC_JAL:            w_fmt = FMT_J;
      OPC_OP:             w_fmt = FMT_R;
      default:            w_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I: w_imm = XLEN'(sext({20'd0, in_instr[31:20]}, 6'd12));
      FMT_S: w_imm = XLEN'(sext({20'd0, in_instr[31:25], in_instr[11:7]}, 6'd12));
      FMT_B: w_imm = XLEN'(sext({19'd0, in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}, 6'd13));
      FMT_U: w_imm = XLEN'(sext({in_instr[31:12], 12'd0}, 6'd32));
      FMT_J: w_imm = XLEN'(sext({11'd0, in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}, 6'd21));
      FMT_SH: begin
        // RV64 shift amounts carry a sixth bit in instr[25].
        if (XLEN == 64) w_imm = XLEN'(in_instr[25:20]);
        else            w_imm = XLEN'(in_instr[24:20]);
      end
      default: w_imm = '0;
    endcase
  end

  skid_buffer #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  ({w_imm, w_fmt, in_instr}),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_data)
  );

  assign out_imm   = w_out_data[PW-1 -: XLEN];
  assign out_fmt   = w_out_data[34:32];
  assign out_instr = w_out_data[31:0];

  // Counted at acceptance so the figure is independent of downstream stalls.
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_accept && (w_fmt == FMT_ILL) && (r_ill_cnt != {CNT_W{1'b1}})) begin
      r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_instr  (out_instr),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode, written with arithmetic shifts on the whole word.
  function automatic logic [2:0] ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h13:               return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'd6 : 3'd1;
      7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
      7'h33:               return 3'd0;
      default:             return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [31:0] s;
    logic signed [31:0] t;
    s = i;
    case (ref_fmt(i))
      3'd1: begin t = s >>> 20; return t; end
      3'd2: begin t = s >>> 20; return (t & 32'hFFFF_FFE0) | {27'd0, i[11:7]}; end
      3'd3: begin
        t = s >>> 19;
        return (t & 32'hFFFF_F000) | ({31'd0, i[7]} << 11) | ({26'd0, i[30:25]} << 5)
               | ({28'd0, i[11:8]} << 1);
      end
      3'd4: return i & 32'hFFFF_F000;
      3'd5: begin
        t = s >>> 11;
        return (t & 32'hFFF0_0000) | ({24'd0, i[19:12]} << 12) | ({31'd0, i[20]} << 11)
               | ({22'd0, i[30:21]} << 1);
      end
      3'd6: return {27'd0, i[24:20]};
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] instr;
  } sb_t;

  sb_t sb[$];

  // Monitor: pushes expectations on accept, pops on delivery, checks hold.
  logic        stall_q = 1'b0;
  logic [31:0] held_imm, held_instr;
  logic [2:0]  held_fmt;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_vld", {63'd0, out_valid}, 64'd1);
        chk("hold_imm", {32'd0, out_imm}, {32'd0, held_imm});
        chk("hold_fmt", {61'd0, out_fmt}, {61'd0, held_fmt});
        chk("hold_instr", {32'd0, out_instr}, {32'd0, held_instr});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", {32'd0, out_instr}, 64'hDEAD_0000_0000_0000);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("sb_imm", {32'd0, out_imm}, {32'd0, e.imm});
          chk("sb_fmt", {61'd0, out_fmt}, {61'd0, e.fmt});
          chk("sb_instr", {32'd0, out_instr}, {32'd0, e.instr});
        end
      end
      stall_q    = out_valid && !out_ready;
      held_imm   = out_imm;
      held_fmt   = out_fmt;
      held_instr = out_instr;
      if (in_valid && in_ready) begin
        sb_t n;
        n.imm   = ref_imm(in_instr);
        n.fmt   = ref_fmt(in_instr);
        n.instr = in_instr;
        sb.push_back(n);
      end
    end
  end

  // Present one instruction and wait (bounded) for its accepting edge.
  // Returns #1 after that edge with in_valid dropped.
  task automatic send(input logic [31:0] ins);
    logic got;
    got      = 1'b0;
    in_instr = ins;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", {63'd0, got}, 64'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opc [12] = '{7'h13, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    logic [31:0] r;
    r      = $urandom();
    r[6:0] = opc[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic rnd_done;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_ill_cnt", {60'd0, illegal_cnt}, 64'd0);
    chk("rst_out_imm", {32'd0, out_imm}, 64'd0);
    chk("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    rst_n = 1'b1;

    // Directed vectors, out_ready held high
    send(32'hFFF0_0093);
    chk("addi_vld", {63'd0, out_valid}, 64'd1);
    chk("addi_imm", {32'd0, out_imm}, 64'hFFFF_FFFF);
    chk("addi_fmt", {61'd0, out_fmt}, 64'd1);
    send(32'hFE11_2E23);
    chk("sw_imm", {32'd0, out_imm}, 64'hFFFF_FFFC);
    chk("sw_fmt", {61'd0, out_fmt}, 64'd2);
    send(32'h1234_50B7);
    chk("lui_imm", {32'd0, out_imm}, 64'h1234_5000);
    chk("lui_fmt", {61'd0, out_fmt}, 64'd4);
    send(32'h4051_5093);
    chk("srai_vld", {63'd0, out_valid}, 64'd1);
    chk("srai_imm", {32'd0, out_imm}, 64'h0000_0005);
    chk("srai_fmt", {61'd0, out_fmt}, 64'd6);
    send(32'h8000_0063);   // beq, offset -4096
    chk("beq_imm", {32'd0, out_imm}, 64'hFFFF_F000);
    send(32'h8000_006F);   // jal, offset -1 MiB
    chk("jal_imm", {32'd0, out_imm}, 64'hFFF0_0000);
    tick(2);
    chk("drain_vld", {63'd0, out_valid}, 64'd0);

    // Back-to-back with the consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0010_0093;              // A
    tick(1);
    chk("stall_rdy_after1", {63'd0, in_ready}, 64'd1);
    chk("stall_outA", {32'd0, out_instr}, 64'h0010_0093);
    in_instr = 32'h0020_0113;               // B
    tick(1);
    chk("stall_rdy_after2", {63'd0, in_ready}, 64'd0);
    in_instr = 32'h0030_0193;               // C, must be held off
    tick(2);
    chk("stall_rdy_held", {63'd0, in_ready}, 64'd0);
    chk("stall_outA_held", {32'd0, out_instr}, 64'h0010_0093);
    chk("stall_sb_two", sb.size(), 64'd2);
    out_ready = 1'b1;
    tick(1);
    chk("rel_outB", {32'd0, out_instr}, 64'h0020_0113);
    chk("rel_rdy", {63'd0, in_ready}, 64'd1);
    tick(1);
    in_valid = 1'b0;
    chk("rel_outC", {32'd0, out_instr}, 64'h0030_0193);
    tick(1);
    chk("rel_empty_vld", {63'd0, out_valid}, 64'd0);
    chk("rel_sb_empty", sb.size(), 64'd0);

    // Illegal opcodes and counter saturation
    send(32'h0000_0000);
    chk("ill_fmt", {61'd0, out_fmt}, 64'd7);
    chk("ill_imm", {32'd0, out_imm}, 64'd0);
    send(32'h0000_0000);
    chk("ill_cnt2", {60'd0, illegal_cnt}, 64'd2);
    for (int k = 0; k < 13; k++) send(32'hFFFF_FFFF);
    chk("ill_cnt_sat", {60'd0, illegal_cnt}, 64'hF);
    for (int k = 0; k < 3; k++) send(32'h0000_007F);
    chk("ill_cnt_stay", {60'd0, illegal_cnt}, 64'hF);
    tick(2);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    send(32'h0050_0293);
    send(32'h0060_0313);
    chk("full_rdy", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", {63'd0, out_valid}, 64'd0);
    chk("arst_rdy", {63'd0, in_ready}, 64'd1);
    chk("arst_cnt", {60'd0, illegal_cnt}, 64'd0);
    chk("arst_imm", {32'd0, out_imm}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (4) begin @(negedge clk); if (out_valid) seen++; end
      chk("arst_no_stale", seen, 64'd0);
    end
    tick(1);

    // Random traffic with random backpressure
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          tick($urandom_range(0, 1));
          send(rand_instr());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    tick(4);
    chk("rnd_sb_empty", sb.size(), 64'd0);
    chk("rnd_vld_idle", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The parameter list SHALL be XLEN, default 32, meaning immediate output width; legal values are 32 and 64.
REQ-002 The parameter list SHALL include CNT_W, default 16, meaning the width of the illegal-opcode counter.
REQ-003 The port clk SHALL be a 1-bit input and the single clock; all state updates on its rising edge.
REQ-004 The port rst_n SHALL be a 1-bit input, asynchronous, active-low reset.
REQ-005 The port in_valid SHALL be a 1-bit input that qualifies in_instr.
REQ-006 The port in_ready SHALL be a 1-bit output; the block accepts in_instr when in_valid and in_ready are both 1.
REQ-007 The port in_instr SHALL be a 32-bit input carrying the raw instruction word.
REQ-008 The port out_valid SHALL be a 1-bit output that qualifies the out_* fields.
REQ-009 The port out_ready SHALL be a 1-bit input; the consumer takes the result when out_valid and out_ready are both 1.
REQ-010 The port out_imm SHALL be an XLEN-bit output carrying the decoded immediate.
REQ-011 The port out_fmt SHALL be a 3-bit output carrying the format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, ILL=7.
REQ-012 The port out_instr SHALL be a 32-bit output passing the instruction through alongside its immediate.
REQ-013 The port illegal_cnt SHALL be a CNT_W-bit output counting illegal opcodes accepted.

Function
REQ-014 Format SHALL come from opcode in_instr[6:0]: 0010011/0000011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R; any other opcode -> ILL.
REQ-015 Opcode 0010011 with funct3 001 or 101 SHALL map to SH instead of I.
REQ-016 Immediates SHALL be built as follows, sign bit is instr[31] throughout:
- I: sext(instr[31:20]).
- S: sext({instr[31:25], instr[11:7]}).
- B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- U: sext({instr[31:12], 12'b0}).
- J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- SH: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
- R and ILL: all zeros.
REQ-017 Latency SHALL be exactly one cycle from an accepting edge to out_valid=1, with a sustained throughput of one result per cycle when out_ready=1.
REQ-018 Output buffering SHALL be a 2-entry skid buffer (main plus skid register), and in_ready SHALL be a registered signal, 0 exactly when the skid entry is occupied.
REQ-019 When out_valid=1 and out_ready=0, out_imm, out_fmt and out_instr SHALL hold stable.
REQ-020 The block SHALL never drop or reorder results.
REQ-021 When accept and deliver happen in the same cycle, the buffer SHALL keep its occupancy and present the next entry.
REQ-022 An input presented while in_ready=0 SHALL be ignored with no state change.
REQ-023 illegal_cnt SHALL increment by 1 on each accepted ILL instruction, counting at acceptance rather than delivery.
REQ-024 illegal_cnt SHALL saturate at all-ones.

Reset
REQ-025 While rst_n=0, the outputs SHALL be:
- out_valid=0, in_ready=1, illegal_cnt=0.
- out_imm=0, out_fmt=0, out_instr=0.
- both buffer entries empty.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered entries immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, the first accept SHALL be possible on the next rising edge.

Structure
REQ-028 The format codes, opcode constants and the sign-extension helper function SHALL live in the shared package imm_gen_pkg.
REQ-029 The buffering SHALL be one sub-module, skid_buffer, parameterised by payload width (XLEN+3+32).
REQ-030 Decode SHALL be combinational logic ahead of skid_buffer.

Verification
REQ-031 The bench SHALL drive 0xFFF00093 (addi x1,x0,-1) with out_ready=1 and check that one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
REQ-032 The bench SHALL drive 0xFE112E23 (sw x1,-4(x2)) and check out_imm=0xFFFFFFFC, out_fmt=2.
REQ-033 The bench SHALL drive 0x123450B7 (lui), then 0x40515093 (srai x1,x2,5), and check out_imm=0x12345000 with fmt=4, then out_imm=0x00000005 with fmt=6.
REQ-034 The bench SHALL hold out_ready=0 while driving three back-to-back instructions and check that:
- in_ready falls after two accepts;
- the third instruction is held off;
- all three emerge in order, outputs stable while stalled, once out_ready=1.
REQ-035 The bench SHALL drive 0x00000000 twice and check out_fmt=7, out_imm=0, illegal_cnt=2; it SHALL then force illegal_cnt to saturation and check that it stays at all-ones.
REQ-036 The bench SHALL assert rst_n=0 with both buffer entries full and check that out_valid=0, in_ready=1, illegal_cnt=0 immediately, with no stale result appearing after release.
